// File: rtl/regfile_mp.sv
// Multi-read-port register file with pending scoreboard and a hardware clear sweep.
// Optional same-cycle write-through forwarding is enabled by defining RF_BYPASS_EN.
module regfile_mp #(
    parameter  int unsigned XLEN  = 32,
    parameter  int unsigned NREGS = 32,
    parameter  int unsigned NRD   = 2,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_pending,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [XLEN-1:0]      wr_data,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic                 clr_req,
    output logic                 clr_busy
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     idx, idx_nxt;
    logic [NREGS-1:0]  pend, pend_nxt;
    logic [XLEN-1:0]   mem [NREGS];
    logic              wr_ok;
    logic              clr_ok;

    // Next-state, sweep index and scoreboard update; issue is applied after write so set wins.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pend_nxt  = pend;
        wr_ok     = 1'b0;
        clr_ok    = 1'b0;
        case (state)
            IDLE: begin
                wr_ok = wr_en && (wr_addr != '0);
                if (wr_ok) begin
                    pend_nxt[wr_addr] = 1'b0;
                end
                if (iss_en && (iss_addr != '0)) begin
                    pend_nxt[iss_addr] = 1'b1;
                end
                if (clr_req) begin
                    state_nxt = SWEEP;
                    idx_nxt   = AW'(1);
                end
            end
            SWEEP: begin
                clr_ok        = 1'b1;
                pend_nxt[idx] = 1'b0;
                idx_nxt       = idx + AW'(1);
                if (idx == AW'(NREGS - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            pend  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            pend  <= pend_nxt;
        end
    end

    // Storage array; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end else if (clr_ok) begin
            mem[idx] <= '0;
        end
    end

    assign clr_busy = (state == SWEEP);

    for (genvar g = 0; g < int'(NRD); g++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            p;

        assign a = rd_addr[g*AW +: AW];

        always_comb begin
            d = mem[a];
            p = pend[a];
            if (a == '0) begin
                d = '0;
                p = 1'b0;
            end
`ifdef RF_BYPASS_EN
            else if (wr_en && (wr_addr == a) && (state == IDLE)) begin
                d = wr_data;
                p = iss_en && (iss_addr == a);
            end
`endif
        end

        assign rd_data[g*XLEN +: XLEN] = d;
        assign rd_pending[g]           = p;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (XLEN=32, NREGS=32, NRD=4).
module tb_regfile_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 4;
    localparam int unsigned AW    = 5;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_pending;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                clr_req;
    logic                clr_busy;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pending (rd_pending),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    function automatic logic [XLEN-1:0] dat(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Point every port at consecutive addresses starting at base and expect zero data / pending.
    task automatic check_all_zero(input string tag);
        for (int a = 0; a < int'(NREGS); a++) begin
            for (int p = 0; p < int'(NRD); p++) set_rd(p, (a + p) % int'(NREGS));
            #1;
            for (int p = 0; p < int'(NRD); p++) begin
                chk({tag, "_data"}, dat(p), '0);
                chk({tag, "_pend"}, XLEN'(rd_pending[p]), '0);
            end
        end
    endtask

    task automatic write_reg(input int a, input logic [XLEN-1:0] v);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic issue_reg(input int a);
        iss_en = 1'b1; iss_addr = AW'(a);
        tick();
        iss_en = 1'b0;
    endtask

    int n;

    initial begin
        reset = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; clr_req = 1'b0;
        #12;
        chk("reset_busy", XLEN'(clr_busy), '0);
        check_all_zero("reset");
        tick();
        reset = 1'b1;
        tick();
        check_all_zero("post_reset");
        chk("idle_busy", XLEN'(clr_busy), '0);

        // Write x5 with same-cycle read on port 0.
        set_rd(0, 5);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        #1;
`ifdef RF_BYPASS_EN
        chk("x5_same_cycle", dat(0), 32'hDEADBEEF);
`else
        chk("x5_same_cycle", dat(0), 32'h0);
`endif
        chk("x5_same_pend", XLEN'(rd_pending[0]), '0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("x5_next_cycle", dat(0), 32'hDEADBEEF);

        // Issue x7, then simultaneous issue+write, then plain write.
        set_rd(1, 7);
        issue_reg(7);
        chk("x7_pend_after_issue", XLEN'(rd_pending[1]), 32'd1);
        chk("x7_data_after_issue", dat(1), '0);
        iss_en = 1'b1; iss_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
        #1;
`ifdef RF_BYPASS_EN
        chk("x7_both_same_data", dat(1), 32'h12);
`else
        chk("x7_both_same_data", dat(1), 32'h0);
`endif
        chk("x7_both_same_pend", XLEN'(rd_pending[1]), 32'd1);
        tick();
        iss_en = 1'b0; wr_en = 1'b0;
        #1;
        chk("x7_both_data", dat(1), 32'h12);
        chk("x7_both_pend", XLEN'(rd_pending[1]), 32'd1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h34;
        #1;
`ifdef RF_BYPASS_EN
        chk("x7_wr_same_pend", XLEN'(rd_pending[1]), 32'd0);
`else
        chk("x7_wr_same_pend", XLEN'(rd_pending[1]), 32'd1);
`endif
        tick();
        wr_en = 1'b0;
        #1;
        chk("x7_wr_pend", XLEN'(rd_pending[1]), 32'd0);
        chk("x7_wr_data", dat(1), 32'h34);

        // x0 stays zero and never pending.
        for (int p = 0; p < int'(NRD); p++) set_rd(p, 0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        for (int p = 0; p < int'(NRD); p++) begin
            chk("x0_same_data", dat(p), '0);
            chk("x0_same_pend", XLEN'(rd_pending[p]), '0);
        end
        tick();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        for (int p = 0; p < int'(NRD); p++) begin
            chk("x0_data", dat(p), '0);
            chk("x0_pend", XLEN'(rd_pending[p]), '0);
        end

        // Fill x1..x31, mark some pending, then sweep.
        for (int k = 1; k < int'(NREGS); k++) write_reg(k, 32'h1000_0000 + XLEN'(k));
        issue_reg(2); issue_reg(9); issue_reg(31);
        set_rd(0, 9); set_rd(1, 31); set_rd(2, 17); set_rd(3, 2);
        #1;
        chk("fill_x9", dat(0), 32'h1000_0009);
        chk("fill_x9_pend", XLEN'(rd_pending[0]), 32'd1);
        chk("fill_x31_pend", XLEN'(rd_pending[1]), 32'd1);
        chk("fill_x17", dat(2), 32'h1000_0011);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("sweep_busy_start", XLEN'(clr_busy), 32'd1);
        n = 0;
        while (clr_busy === 1'b1 && n < 100) begin
            tick();
            n++;
            wr_en = 1'b0; iss_en = 1'b0;
            if (n == 5) begin
                set_rd(1, 3);
                chk("sweep_live_x9", dat(0), 32'h1000_0009);
                chk("sweep_live_x2", dat(3), '0);
                chk("sweep_live_x2_pend", XLEN'(rd_pending[3]), '0);
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA_5555; iss_en = 1'b1; iss_addr = 5'd3;
                #1;
                chk("sweep_no_bypass_x3", dat(1), '0);
                chk("sweep_no_bypass_pend", XLEN'(rd_pending[1]), '0);
            end
        end
        chk("sweep_busy_cycles", XLEN'(n), 32'd31);
        wr_en = 1'b0; iss_en = 1'b0;
        check_all_zero("after_sweep");

        // Reset in the middle of a sweep.
        write_reg(20, 32'h20);
        issue_reg(25);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        set_rd(0, 20); set_rd(1, 25);
        #1;
        chk("midsweep_busy", XLEN'(clr_busy), 32'd1);
        chk("midsweep_x20", dat(0), 32'h20);
        chk("midsweep_x25_pend", XLEN'(rd_pending[1]), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", XLEN'(clr_busy), '0);
        chk("abort_x20", dat(0), '0);
        chk("abort_x25_pend", XLEN'(rd_pending[1]), '0);
        check_all_zero("abort");
        tick();
        reset = 1'b1;
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0;
        while (clr_busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("resweep_busy_cycles", XLEN'(n), 32'd31);
        chk("resweep_idle", XLEN'(clr_busy), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file with write-through bypass, a per-register pending scoreboard, and a hardware clear sequencer. It sits in the decode stage of the pipelined CPU. It supplies operands and hazard status for up to four source operands per cycle. It accepts one writeback per cycle from the WB stage and one destination reservation per cycle from the issue logic. Register 0 is hard-wired to zero and is never pending.

## Interface
- XLEN, 32, data width in bits (8..64)
- NREGS, 32, number of registers; power of two, 4..64
- NRD, 2, number of read ports (1..4)
- AW, $clog2(NREGS), address width; derived, not overridden

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rd_pending  out  NRD  scoreboard bit of each addressed register
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback register
- wr_data  in  XLEN  writeback data
- iss_en  in  1  reserve destination register (set pending)
- iss_addr  in  AW  destination being reserved
- clr_req  in  1  start clear sweep (sampled in IDLE only)
- clr_busy  out  1  sweep in progress

## Operation
- Storage: NREGS x XLEN array plus an NREGS-bit pending vector. Entry 0 and pend[0] are always 0; writes and issues to address 0 are dropped.
- Write: when wr_en=1, wr_addr!=0 and state is IDLE, array[wr_addr] <= wr_data at the rising edge, and pend[wr_addr] is cleared at the same edge.
- Issue: when iss_en=1, iss_addr!=0 and state is IDLE, pend[iss_addr] is set at the rising edge.
- Simultaneous issue and write to the same register: set wins, so pend stays 1 because a newer producer exists. The data is still written.
- Read port i (combinational, checked in this order):
  - if rd_addr_i==0: data 0, pending 0
  - else if bypass hit (wr_en, wr_addr==rd_addr_i, IDLE): data = wr_data, pending = (iss_en && iss_addr==rd_addr_i)
  - else: data = array entry, pending = pend bit
- Several ports may read the same address; each returns an identical result.
- FSM states:
  - IDLE -> SWEEP when clr_req=1 at the edge; the index counter loads 1.
  - SWEEP: each edge zeroes array[idx] and pend[idx], then idx increments.
  - SWEEP -> IDLE on the edge that clears idx==NREGS-1.
- clr_req is ignored while in SWEEP.
- During SWEEP, wr_en and iss_en are ignored, there is no bypass, and reads return live array contents (entries already cleared read 0).
- Reset (asserted low, asynchronous):
  - all entries and pend bits go to 0, state goes to IDLE, idx goes to 0
  - clr_busy=0
  - rd_data and rd_pending reflect the zeroed array immediately
- Reset asserted mid-sweep aborts the sweep at once.

## Timing
- Read path is zero-latency combinational: address to data in the same cycle.
- Writes and issues are visible through the array one cycle later, and same-cycle through the bypass.
- Sweep: clr_req is sampled at edge t. clr_busy is high from just after edge t until just after edge t+NREGS-1 (NREGS-1 cycles). Entry k is cleared at edge t+k.
- clr_busy is a registered output (decoded from the state flop). No output is combinational from clr_req.
- Back-to-back clr_req is accepted on the first edge after returning to IDLE.

## Configuration
- RF_BYPASS_EN defined: write-through forwarding as above. rd_pending is masked by the same-cycle writeback.
- RF_BYPASS_EN undefined: reads return array contents and pend bits only. A value written at edge t is readable after edge t. Downstream logic must stall one extra cycle. All other behaviour is identical.

## Test plan
- Reset, then read all addresses on all ports -> all rd_data=0, rd_pending=0, clr_busy=0.
- Write x5=0xDEADBEEF; in the same cycle, read x5 on port 0 -> with RF_BYPASS_EN, 0xDEADBEEF the same cycle; without it, 0 that cycle and 0xDEADBEEF the next.
- Issue x7; next cycle rd_pending(x7)=1. Then assert iss_en x7 and wr_en x7=0x12 in the same cycle -> pending stays 1 and data reads 0x12. Then write x7 alone -> pending 0.
- Write to x0 with 0xFFFFFFFF and issue x0 -> x0 reads 0 and pending 0 on every port.
- NREGS=32: fill x1..x31 with nonzero values and set some pend bits, then pulse clr_req -> clr_busy high exactly 31 cycles, a write to x3 during the sweep is dropped, and afterwards all entries and pend bits are 0.
- Start a sweep, assert reset low at cycle 10 -> clr_busy=0 immediately, all entries 0, and the next clr_req starts a full 31-cycle sweep.
